// File: rtl/expbus_mailbox_pkg.sv
// expbus_mailbox_pkg
// Shared constants for the expansion-port mailbox: register offsets,
// status/control bit positions, the idle bus value, and a status packer.
package expbus_mailbox_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int ST_RX_NE    = 0;
  localparam int ST_TX_NF    = 1;
  localparam int ST_RX_UNDER = 2;
  localparam int ST_TX_OVER  = 3;
  localparam int ST_IEN      = 6;
  localparam int ST_IRQ      = 7;

  localparam int CTL_IEN   = 0;
  localparam int CTL_CLR   = 4;
  localparam int CTL_FLUSH = 5;

  localparam logic [7:0] BUS_IDLE = 8'hFF;

  function automatic logic [7:0] pack_status(input logic rx_ne, input logic tx_nf,
                                             input logic rx_under, input logic tx_over,
                                             input logic ien, input logic irq_now);
    logic [7:0] s;
    s = 8'h00;
    s[ST_RX_NE]    = rx_ne;
    s[ST_TX_NF]    = tx_nf;
    s[ST_RX_UNDER] = rx_under;
    s[ST_TX_OVER]  = tx_over;
    s[ST_IEN]      = ien;
    s[ST_IRQ]      = irq_now;
    return s;
  endfunction

endpackage

// File: rtl/expbus_fifo.sv
// expbus_fifo
// Synchronous byte FIFO, depth 2**AW. Flush has priority over push/pop.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   push, din          write request and data (ignored when full)
//   pop, dout          read request (ignored when empty); dout is the head
//   flush              clears pointers and count
//   empty, full, count occupancy (count is AW+1 bits)
module expbus_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // count can only reach DEPTH, so its MSB alone marks full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/expbus_mailbox.sv
// expbus_mailbox
// Z80 expansion-port I/O mailbox. BASE_ADDR is the data register (RX pop on
// read, TX push on write); BASE_ADDR+1 is status (read) / control (write).
// Ports:
//   clk, reset_n              clock, async active-low reset
//   cpu_addr, cpu_dout        Z80 address and write data
//   iorq, rd, wr, m1          active-high bus strobes (iorq&m1 = INTA, ignored)
//   cpu_din                   read data, 8'hFF when not driving
//   irq                       level interrupt: irq_en & RX not empty
//   rx_data/rx_valid/rx_ready host-to-CPU stream
//   tx_data/tx_valid/tx_ready CPU-to-host stream
module expbus_mailbox
  import expbus_mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFBD0,
  parameter int          FIFO_AW   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  output logic [7:0]  cpu_din,
  output logic        irq,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic             sel;
  logic             reg_sel;
  logic             io_rd;
  logic             io_wr;
  logic             io_rd_q;
  logic             io_wr_q;
  logic             rd_arm;
  logic             wr_arm;
  logic             rd_rise;
  logic             rd_fall;
  logic             wr_rise;
  logic             rd_pend;
  logic [7:0]       din_q;
  logic             rx_under;
  logic             tx_over;
  logic             irq_en;
  logic             flush;
  logic [7:0]       status;

  logic             rx_push;
  logic             rx_pop;
  logic [7:0]       rx_dout;
  logic             rx_empty;
  logic             rx_full;
  logic [FIFO_AW:0] rx_count;

  logic             tx_push;
  logic             tx_pop;
  logic             tx_empty;
  logic             tx_full;
  logic [FIFO_AW:0] tx_count;

  assign sel     = iorq & ~m1 & (cpu_addr[15:1] == BASE_ADDR[15:1]);
  assign reg_sel = cpu_addr[0];
  assign io_rd   = sel & rd;
  assign io_wr   = sel & wr;

  // The arm flags only set once the strobe has been seen low, so a strobe
  // already high when reset releases never counts as a rising edge.
  assign rd_rise = io_rd & ~io_rd_q & rd_arm;
  assign rd_fall = ~io_rd & io_rd_q;
  assign wr_rise = io_wr & ~io_wr_q & wr_arm;

  assign flush   = wr_rise & (reg_sel == REG_STAT) & cpu_dout[CTL_FLUSH];

  assign status  = pack_status(rx_count != '0, ~tx_count[FIFO_AW], rx_under, tx_over,
                               irq_en, irq);

  assign rx_ready = ~rx_full & ~flush;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_fall & rd_pend;

  assign tx_valid = ~tx_empty & ~flush;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = wr_rise & (reg_sel == REG_DATA) & ~tx_full;

  assign cpu_din  = io_rd ? din_q : BUS_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_rd_q  <= 1'b0;
      io_wr_q  <= 1'b0;
      rd_arm   <= 1'b0;
      wr_arm   <= 1'b0;
      rd_pend  <= 1'b0;
      din_q    <= BUS_IDLE;
      rx_under <= 1'b0;
      tx_over  <= 1'b0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      io_rd_q <= io_rd;
      io_wr_q <= io_wr;
      if (!io_rd) rd_arm <= 1'b1;
      if (!io_wr) wr_arm <= 1'b1;

      if (rd_rise) begin
        if (reg_sel == REG_STAT) begin
          din_q <= status;
        end else if (rx_empty) begin
          din_q    <= BUS_IDLE;
          rx_under <= 1'b1;
        end else begin
          din_q   <= rx_dout;
          rd_pend <= 1'b1;
        end
      end else if (!io_rd) begin
        din_q <= BUS_IDLE;
      end

      if (rd_fall) rd_pend <= 1'b0;

      if (wr_rise) begin
        if (reg_sel == REG_DATA) begin
          if (tx_full) tx_over <= 1'b1;
        end else begin
          irq_en <= cpu_dout[CTL_IEN];
          if (cpu_dout[CTL_CLR]) begin
            rx_under <= 1'b0;
            tx_over  <= 1'b0;
          end
        end
      end

      irq <= irq_en & (rx_count != '0);
    end
  end

  expbus_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .flush   (flush),
    .din     (rx_data),
    .dout    (rx_dout),
    .empty   (rx_empty),
    .full    (rx_full),
    .count   (rx_count)
  );

  expbus_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .pop     (tx_pop),
    .flush   (flush),
    .din     (cpu_dout),
    .dout    (tx_data),
    .empty   (tx_empty),
    .full    (tx_full),
    .count   (tx_count)
  );

endmodule

// File: tb/tb_expbus_mailbox.sv
// tb_expbus_mailbox
// Scoreboard bench: stimulus tasks update a queue-based reference model and
// push expected CPU read data; monitors compare cpu_din and the TX stream.
module tb_expbus_mailbox;

  localparam logic [15:0] A_DATA = 16'hFBD0;
  localparam logic [15:0] A_STAT = 16'hFBD1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        iorq, rd, wr, m1;
  logic [7:0]  cpu_din;
  logic        irq;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_rd[$];
  bit und_m, ovr_m, ien_m;
  bit mon_en, tx_rand, tx_force;

  expbus_mailbox #(.BASE_ADDR(16'hFBD0), .FIFO_AW(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .iorq     (iorq),
    .rd       (rd),
    .wr       (wr),
    .m1       (m1),
    .cpu_din  (cpu_din),
    .irq      (irq),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] stat_exp();
    logic irq_m;
    irq_m = ien_m && (rx_q.size() > 0);
    return {irq_m, ien_m, 2'b00, ovr_m, und_m, (tx_q.size() < 16), (rx_q.size() > 0)};
  endfunction

  // CPU IN: strobe held for 'hold' clocks, then one idle clock
  task automatic cpu_in(input logic [15:0] a, input int hold,
                        input bit push_at_fall = 1'b0, input logic [7:0] pd = 8'h00);
    logic [7:0] e;
    @(posedge clk); #1;
    if (a[0]) e = stat_exp();
    else if (rx_q.size() == 0) begin
      e = 8'hFF;
      und_m = 1'b1;
    end else e = rx_q.pop_front();
    if (mon_en) exp_rd.push_back(e);
    cpu_addr = a; iorq = 1'b1; rd = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    iorq = 1'b0; rd = 1'b0;
    if (push_at_fall) begin
      rx_data = pd; rx_valid = 1'b1; rx_q.push_back(pd);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // CPU OUT; optional concurrent host push in the action cycle
  task automatic cpu_out(input logic [15:0] a, input logic [7:0] d,
                         input bit hpush = 1'b0, input logic [7:0] pd = 8'h00);
    @(posedge clk); #1;
    cpu_addr = a; cpu_dout = d; iorq = 1'b1; wr = 1'b1;
    if (hpush) begin
      rx_data = pd; rx_valid = 1'b1;
    end
    if (!a[0]) begin
      if (tx_q.size() >= 16) ovr_m = 1'b1;
      else tx_q.push_back(d);
    end else begin
      ien_m = d[0];
      if (d[4]) begin und_m = 1'b0; ovr_m = 1'b0; end
      if (d[5]) begin
        rx_q.delete(); tx_q.delete();
      end else if (hpush) rx_q.push_back(pd);
    end
    @(negedge clk);
    if (hpush && d[5] && a[0]) begin
      check("rx_ready_in_flush", rx_ready, 8'h00);
      check("tx_valid_in_flush", tx_valid, 8'h00);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    iorq = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic host_push(input logic [7:0] d);
    @(posedge clk); #1;
    check("rx_ready", rx_ready, (rx_q.size() < 16));
    rx_data = d; rx_valid = 1'b1; rx_q.push_back(d);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (tx_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL tx_drain: %0d bytes left, expected 0", tx_q.size());
    end
    @(posedge clk); #1;
    check("tx_valid_after_drain", tx_valid, 8'h00);
  endtask

  // read monitor: compares cpu_din while a decoded data/status read is active
  initial begin : rd_mon
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && iorq && rd && !m1 && (cpu_addr[15:1] == A_DATA[15:1])) begin
        if (prev) begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got %h expected no read", cpu_din);
          end else check("rd_data", cpu_din, exp_rd[0]);
        end
        prev = 1'b1;
      end else begin
        if (prev && exp_rd.size() > 0) void'(exp_rd.pop_front());
        prev = 1'b0;
        if (mon_en && reset_n) check("rd_idle", cpu_din, 8'hFF);
      end
    end
  end

  // TX monitor: every handshake must deliver the model's head byte
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
        end else check("tx_data", tx_data, tx_q.pop_front());
      end
    end
  end

  initial begin : tx_ready_drv
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : tx_force;
    end
  end

  initial begin : main
    logic [7:0] d;
    reset_n = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
    iorq = 1'b0; rd = 1'b0; wr = 1'b0; m1 = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0;
    tx_force = 1'b0; tx_rand = 1'b0; mon_en = 1'b1;
    und_m = 1'b0; ovr_m = 1'b0; ien_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_din", cpu_din, 8'hFF);
    check("rst_irq", irq, 8'h00);
    check("rst_tx_valid", tx_valid, 8'h00);
    check("rst_rx_ready", rx_ready, 8'h01);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // two bytes through RX, then status
    host_push(8'h41); host_push(8'h42);
    cpu_in(A_DATA, 2); cpu_in(A_DATA, 2); cpu_in(A_STAT, 2);

    // underrun and clear
    cpu_in(A_DATA, 3); cpu_in(A_STAT, 2);
    cpu_out(A_STAT, 8'h10); cpu_in(A_STAT, 2);

    // TX overrun with host stalled, then drain in order
    for (int i = 0; i < 17; i++) cpu_out(A_DATA, 8'hA0 + 8'(i));
    cpu_in(A_STAT, 2);
    tx_force = 1'b1;
    wait_tx_drain();
    cpu_out(A_STAT, 8'h10);

    // irq, INTA ignored, irq drop after pop
    cpu_out(A_STAT, 8'h01);
    host_push(8'h55);
    @(posedge clk); #1;
    check("irq_set", irq, 8'h01);
    @(posedge clk); #1;
    cpu_addr = A_DATA; iorq = 1'b1; m1 = 1'b1; rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("inta_cpu_din", cpu_din, 8'hFF);
    iorq = 1'b0; m1 = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    check("irq_after_inta", irq, 8'h01);
    cpu_in(A_DATA, 2);
    @(posedge clk); #1;
    check("irq_clear", irq, 8'h00);

    // long read strobe, simultaneous push/pop at count 3
    host_push(8'h61); host_push(8'h62); host_push(8'h63);
    cpu_in(A_DATA, 20);
    host_push(8'h64);
    cpu_in(A_DATA, 2, 1'b1, 8'h77);
    cpu_in(A_STAT, 2);
    for (int i = 0; i < 4; i++) cpu_in(A_DATA, 2);
    cpu_out(A_STAT, 8'h10);

    // reset in the middle of an IN
    for (int i = 0; i < 5; i++) host_push(8'hB0 + 8'(i));
    mon_en = 1'b0;
    @(posedge clk); #1;
    cpu_addr = A_DATA; iorq = 1'b1; rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_cpu_din", cpu_din, 8'hFF);
    check("midrst_rx_ready", rx_ready, 8'h01);
    check("midrst_irq", irq, 8'h00);
    check("midrst_tx_valid", tx_valid, 8'h00);
    rx_q.delete(); tx_q.delete(); exp_rd.delete();
    und_m = 1'b0; ovr_m = 1'b0; ien_m = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("held_strobe_no_action", cpu_din, 8'hFF);
    iorq = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    cpu_in(A_STAT, 2);

    // flush concurrent with host push
    tx_force = 1'b0;
    cpu_out(A_DATA, 8'h11); cpu_out(A_DATA, 8'h12);
    host_push(8'h01);
    cpu_out(A_STAT, 8'h20, 1'b1, 8'h99);
    check("flush_tx_valid", tx_valid, 8'h00);
    cpu_in(A_STAT, 2);
    cpu_in(A_DATA, 2);

    // randomized mix
    tx_rand = 1'b1;
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0, 1: if (rx_q.size() < 16) host_push(8'($urandom));
        2:    cpu_in(A_DATA, $urandom_range(2, 4));
        3:    cpu_in(A_STAT, 2);
        4:    if (tx_q.size() < 12) cpu_out(A_DATA, 8'($urandom));
        default: begin
          d = 8'($urandom) & 8'hDF;
          if ($urandom_range(0, 9) == 0) d[5] = 1'b1;
          cpu_out(A_STAT, d);
        end
      endcase
    end
    tx_rand = 1'b0;
    tx_force = 1'b1;
    wait_tx_drain();
    cpu_in(A_STAT, 2);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
